// File: rtl/gpio_in_if.sv
// ----------------------------------------------------------------------------
// gpio_in_if
//   CPU-side register bus for the gpio_in block: block select, load and
//   store strobes, word offset, store data, registered load data and the
//   interrupt request.
//
//   master : the CPU / address decoder driving accesses
//   slave  : the gpio_in register block
//
//   sel      address decoded to this block's window
//   re       load access (qualified by sel)
//   we       store access (qualified by sel)
//   addr     word offset: 0=DATA 1=EDGE 2=IRQ_EN 3=reserved
//   wr_data  store data
//   rd_data  load data, one cycle after issue, zero when idle
//   irq      level interrupt request
// ----------------------------------------------------------------------------
interface gpio_in_if;
    logic        sel;
    logic        re;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    modport master (
        output sel, re, we, addr, wr_data,
        input  rd_data, irq
    );

    modport slave (
        input  sel, re, we, addr, wr_data,
        output rd_data, irq
    );
endinterface

// File: rtl/gpio_in.sv
// ----------------------------------------------------------------------------
// gpio_in
//   Memory-mapped GPIO input port. Raw pins are synchronised with two flops,
//   then each bit is debounced: a new level must persist for DB_CYCLES
//   consecutive cycles before it is accepted into the stable value. Rising
//   edges of the stable value set sticky EDGE flags (write-1-to-clear), and
//   irq is raised when any enabled flag is set.
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     gpio_in_i  raw external pins, asynchronous to clk
//     bus        register bus (slave modport of gpio_in_if)
//
//   Register map (word offsets)
//     0  DATA    debounced pin levels, read-only
//     1  EDGE    sticky rising-edge flags, write 1 to clear
//     2  IRQ_EN  per-bit interrupt enable
//     3  reserved, reads 0, writes ignored
// ----------------------------------------------------------------------------
module gpio_in #(
    parameter int WIDTH     = 8,
    parameter int DB_CNT_W  = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_in_i,
    gpio_in_if.slave         bus
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

    // Terminal count: the change is accepted on the cycle the counter
    // would otherwise reach DB_CYCLES, so the counter never exceeds this.
    localparam logic [DB_CNT_W-1:0] CNT_TC = DB_CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0]    sync1_q;
    logic [WIDTH-1:0]    sync2_q;
    logic [WIDTH-1:0]    stable_q;
    logic [WIDTH-1:0]    stable_d;
    logic [DB_CNT_W-1:0] cnt_q [WIDTH];
    logic [DB_CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]    edge_q;
    logic [WIDTH-1:0]    edge_d;
    logic [WIDTH-1:0]    irq_en_q;
    logic [WIDTH-1:0]    irq_en_d;
    logic [31:0]         rd_data_q;
    logic [31:0]         rd_data_d;
    logic                irq_q;
    logic                irq_d;
    logic [WIDTH-1:0]    rise;
    logic                wr_en;
    logic                rd_en;

    // Store data above WIDTH carries no meaning for this block.
    logic unused_wr_data;
    assign unused_wr_data = ^bus.wr_data[31:WIDTH];

    assign wr_en = bus.sel & bus.we;
    assign rd_en = bus.sel & bus.re;

    // ------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce: count consecutive cycles where the synchronised
    // level disagrees with the accepted level; any agreement restarts it.
    // ------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // ------------------------------------------------------------------
    // Register writes. A rise in the same cycle as a clear keeps the flag
    // set so no edge is ever lost to a racing acknowledge.
    // ------------------------------------------------------------------
    always_comb begin
        edge_d   = edge_q | rise;
        irq_en_d = irq_en_q;
        if (wr_en) begin
            case (bus.addr)
                ADDR_EDGE:   edge_d   = (edge_q & ~bus.wr_data[WIDTH-1:0]) | rise;
                ADDR_IRQ_EN: irq_en_d = bus.wr_data[WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register reads return the pre-update value; idle cycles return 0 so
    // the result can be OR-ed onto a shared load bus.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            case (bus.addr)
                ADDR_DATA:   rd_data_d = 32'(stable_q);
                ADDR_EDGE:   rd_data_d = 32'(edge_q);
                ADDR_IRQ_EN: rd_data_d = 32'(irq_en_q);
                default:     rd_data_d = '0;
            endcase
        end
    end

    // irq follows the next-state flags so it tracks them with no extra lag.
    assign irq_d = |(edge_d & irq_en_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q    <= '0;
            irq_en_q  <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            edge_q    <= edge_d;
            irq_en_q  <= irq_en_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.irq     = irq_q;

endmodule

// File: tb/tb_gpio_in.sv
module tb_gpio_in;

    logic       clk;
    logic       rst_n;
    logic [7:0] gpio;
    int         cmp_cnt;
    int         fail_cnt;

    gpio_in_if bus ();

    gpio_in #(
        .WIDTH     (8),
        .DB_CNT_W  (16),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_in_i (gpio),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.sel  = 1'b1;
        bus.re   = 1'b1;
        bus.addr = a;
        tick(1);
        d        = bus.rd_data;
        bus.sel  = 1'b0;
        bus.re   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        bus.sel     = 1'b1;
        bus.we      = 1'b1;
        bus.addr    = a;
        bus.wr_data = v;
        tick(1);
        bus.sel     = 1'b0;
        bus.we      = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b1;
        gpio  = 8'hFF;
        tick(4);                         // debounce in progress
        rst_n = 1'b0;
        #1;
        if (bus.rd_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_rd_data: got %h expected %h", bus.rd_data, 32'h0);
        end
        cmp_cnt++;
        if (bus.irq !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_irq: got %b expected 0", bus.irq);
        end
        cmp_cnt++;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        bus.sel  = 1'b1;
        bus.re   = 1'b1;
        bus.addr = 2'd0;
        tick(1);                         // 6th edge: value returned is pre-update
        if (bus.rd_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_data_early: got %h expected %h", bus.rd_data, 32'h0);
        end
        cmp_cnt++;
        tick(1);
        if (bus.rd_data !== 32'hFF) begin
            fail_cnt++;
            $display("FAIL reset_data_late: got %h expected %h", bus.rd_data, 32'hFF);
        end
        cmp_cnt++;
        bus.sel = 1'b0;
        bus.re  = 1'b0;
        rd(2'd1, d);
        if (d !== 32'hFF) begin
            fail_cnt++;
            $display("FAIL reset_edge_set: got %h expected %h", d, 32'hFF);
        end
        cmp_cnt++;
        gpio = 8'h00;
        tick(8);
        wr(2'd1, 32'hFF);
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        gpio = 8'h01;
        tick(3);
        gpio = 8'h00;
        tick(8);
        rd(2'd0, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL glitch_data: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        rd(2'd1, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL glitch_edge: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        gpio = 8'h01;
        tick(5);
        rd(2'd0, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL hold_data_early: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        rd(2'd0, d);
        if (d !== 32'h01) begin
            fail_cnt++;
            $display("FAIL hold_data: got %h expected %h", d, 32'h01);
        end
        cmp_cnt++;
        rd(2'd1, d);
        if (d !== 32'h01) begin
            fail_cnt++;
            $display("FAIL hold_edge: got %h expected %h", d, 32'h01);
        end
        cmp_cnt++;
    endtask

    task automatic test_read_latency;
        logic [31:0] d;
        gpio = 8'hA5;
        tick(8);
        rd(2'd0, d);
        if (d !== 32'h000000A5) begin
            fail_cnt++;
            $display("FAIL read_data: got %h expected %h", d, 32'hA5);
        end
        cmp_cnt++;
        tick(1);
        if (bus.rd_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL read_idle_zero: got %h expected %h", bus.rd_data, 32'h0);
        end
        cmp_cnt++;
        rd(2'd1, d);
        if (d !== 32'hA5) begin
            fail_cnt++;
            $display("FAIL read_edge: got %h expected %h", d, 32'hA5);
        end
        cmp_cnt++;
    endtask

    task automatic test_w1c;
        logic [31:0] d;
        gpio = 8'hA4;
        tick(8);
        wr(2'd1, 32'hFF);
        rd(2'd1, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL w1c_clear_all: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        gpio = 8'hA5;
        tick(5);
        wr(2'd1, 32'h01);                // lands on the edge where bit 0 rises
        rd(2'd1, d);
        if (d !== 32'h01) begin
            fail_cnt++;
            $display("FAIL w1c_race: got %h expected %h", d, 32'h01);
        end
        cmp_cnt++;
        gpio = 8'hA7;
        tick(8);
        rd(2'd1, d);
        if (d !== 32'h03) begin
            fail_cnt++;
            $display("FAIL w1c_pre: got %h expected %h", d, 32'h03);
        end
        cmp_cnt++;
        wr(2'd1, 32'h02);
        rd(2'd1, d);
        if (d !== 32'h01) begin
            fail_cnt++;
            $display("FAIL w1c_partial: got %h expected %h", d, 32'h01);
        end
        cmp_cnt++;
        wr(2'd1, 32'h01);
        rd(2'd1, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL w1c_clear: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
    endtask

    task automatic test_irq;
        logic [31:0] d;
        wr(2'd2, 32'h04);
        rd(2'd2, d);
        if (d !== 32'h04) begin
            fail_cnt++;
            $display("FAIL irq_en_read: got %h expected %h", d, 32'h04);
        end
        cmp_cnt++;
        gpio = 8'hA3;
        tick(8);
        gpio = 8'hA7;
        tick(5);
        if (bus.irq !== 1'b0) begin
            fail_cnt++;
            $display("FAIL irq_early: got %b expected 0", bus.irq);
        end
        cmp_cnt++;
        tick(1);
        if (bus.irq !== 1'b1) begin
            fail_cnt++;
            $display("FAIL irq_set: got %b expected 1", bus.irq);
        end
        cmp_cnt++;
        wr(2'd1, 32'h04);
        if (bus.irq !== 1'b0) begin
            fail_cnt++;
            $display("FAIL irq_clear: got %b expected 0", bus.irq);
        end
        cmp_cnt++;
        gpio = 8'hA5;
        tick(8);
        gpio = 8'hA7;
        tick(8);
        if (bus.irq !== 1'b0) begin
            fail_cnt++;
            $display("FAIL irq_masked: got %b expected 0", bus.irq);
        end
        cmp_cnt++;
        rd(2'd1, d);
        if (d !== 32'h02) begin
            fail_cnt++;
            $display("FAIL irq_masked_edge: got %h expected %h", d, 32'h02);
        end
        cmp_cnt++;
        wr(2'd2, 32'h02);
        if (bus.irq !== 1'b1) begin
            fail_cnt++;
            $display("FAIL irq_enable_write: got %b expected 1", bus.irq);
        end
        cmp_cnt++;
        wr(2'd2, 32'h00);
        if (bus.irq !== 1'b0) begin
            fail_cnt++;
            $display("FAIL irq_disable_write: got %b expected 0", bus.irq);
        end
        cmp_cnt++;
    endtask

    task automatic test_reserved;
        logic [31:0] d;
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'hFF);
        bus.sel     = 1'b0;              // unselected store must be ignored
        bus.we      = 1'b1;
        bus.addr    = 2'd2;
        bus.wr_data = 32'hFF;
        tick(1);
        bus.we      = 1'b0;
        bus.wr_data = '0;
        rd(2'd0, d);
        if (d !== 32'hA7) begin
            fail_cnt++;
            $display("FAIL rsv_data: got %h expected %h", d, 32'hA7);
        end
        cmp_cnt++;
        rd(2'd1, d);
        if (d !== 32'h02) begin
            fail_cnt++;
            $display("FAIL rsv_edge: got %h expected %h", d, 32'h02);
        end
        cmp_cnt++;
        rd(2'd2, d);
        if (d !== 32'h00) begin
            fail_cnt++;
            $display("FAIL rsv_irq_en: got %h expected %h", d, 32'h00);
        end
        cmp_cnt++;
        rd(2'd3, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL rsv_addr3: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
    endtask

    task automatic test_read_write_same_cycle;
        logic [31:0] d;
        bus.sel     = 1'b1;
        bus.re      = 1'b1;
        bus.we      = 1'b1;
        bus.addr    = 2'd2;
        bus.wr_data = 32'h55;
        tick(1);
        d           = bus.rd_data;
        bus.sel     = 1'b0;
        bus.re      = 1'b0;
        bus.we      = 1'b0;
        bus.wr_data = '0;
        if (d !== 32'h00) begin
            fail_cnt++;
            $display("FAIL rw_pre_value: got %h expected %h", d, 32'h00);
        end
        cmp_cnt++;
        rd(2'd2, d);
        if (d !== 32'h55) begin
            fail_cnt++;
            $display("FAIL rw_post_value: got %h expected %h", d, 32'h55);
        end
        cmp_cnt++;
    endtask

    task automatic test_reset_state;
        logic [31:0] d;
        wr(2'd2, 32'h02);                // EDGE=02 so irq goes high
        gpio     = 8'h00;
        bus.sel  = 1'b1;
        bus.re   = 1'b1;
        bus.addr = 2'd1;
        tick(1);
        if (bus.irq !== 1'b1 || bus.rd_data !== 32'h02) begin
            fail_cnt++;
            $display("FAIL pre_reset: irq %b rd %h expected 1 / %h", bus.irq, bus.rd_data, 32'h02);
        end
        cmp_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.irq !== 1'b0 || bus.rd_data !== 32'h0) begin
            fail_cnt++;
            $display("FAIL async_reset: irq %b rd %h expected 0 / 0", bus.irq, bus.rd_data);
        end
        cmp_cnt++;
        bus.sel = 1'b0;
        bus.re  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        rd(2'd1, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_edge: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        rd(2'd2, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_irq_en: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
        rd(2'd0, d);
        if (d !== 32'h0) begin
            fail_cnt++;
            $display("FAIL reset_data: got %h expected %h", d, 32'h0);
        end
        cmp_cnt++;
    endtask

    initial begin
        cmp_cnt     = 0;
        fail_cnt    = 0;
        rst_n       = 1'b0;
        gpio        = 8'h00;
        bus.sel     = 1'b0;
        bus.re      = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = 2'd0;
        bus.wr_data = '0;
        tick(3);
        test_reset();
        test_glitch();
        test_read_latency();
        test_w1c();
        test_irq();
        test_reserved();
        test_read_write_same_cycle();
        test_reset_state();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
